// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, ACK/NACK line
// levels and the position of the R/W bit inside the address byte.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_IGNORE
    } state_t;

    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;
    localparam int   RW_BIT = 0;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one open-drain bus line, with rise/fall strobes
// derived from the synchronized level against its one-cycle-delayed copy.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], line_i};
        prev_d = sync_q[1];
    end

    // Lines idle high through their pull-ups, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~prev_q;
    assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target endpoint: START/STOP detection, 7-bit address match, byte receive
// and transmit, with SDA updates delayed SDA_HOLD clocks after each SCL fall.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int SDA_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    output logic       busy,
    output logic       addressed,
    output logic       read_nwrite,
    output logic [7:0] data_o,
    output logic       data_valid,
    output logic       data_request,
    input  logic [7:0] data_i,
    input  logic       SCL_i,
    input  logic       SDA_i,
    output logic       SDA_o,
    output logic       SDA_t
);

    localparam int HOLD_W = (SDA_HOLD > 1) ? $clog2(SDA_HOLD) : 1;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (SCL_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (SDA_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start_det = scl_lvl & sda_fall;
    assign stop_det  = scl_lvl & sda_rise;

    state_t              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          tx_q, tx_d;
    logic [7:0]          data_o_q, data_o_d;
    logic                busy_q, busy_d;
    logic                addressed_q, addressed_d;
    logic                rnw_q, rnw_d;
    logic                data_valid_q, data_valid_d;
    logic                data_request_q, data_request_d;
    logic                ack_rise_q, ack_rise_d;
    logic                sda_t_q, sda_t_d;
    logic                pend_q, pend_d;
    logic                pend_val_q, pend_val_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [7:0]          rx_byte;
    logic                sched, sched_val;

    // ack_rise_q separates the SCL fall that starts an ACK slot from the one that ends it.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        tx_d           = tx_q;
        data_o_d       = data_o_q;
        busy_d         = busy_q;
        addressed_d    = addressed_q;
        rnw_d          = rnw_q;
        data_valid_d   = 1'b0;
        data_request_d = 1'b0;
        ack_rise_d     = ack_rise_q;
        sda_t_d        = sda_t_q;
        pend_d         = pend_q;
        pend_val_d     = pend_val_q;
        hold_cnt_d     = hold_cnt_q;
        rx_byte        = {shift_q[6:0], sda_lvl};
        sched          = 1'b0;
        sched_val      = NACK;

        if (pend_q) begin
            if (hold_cnt_q == '0) begin
                sda_t_d = pend_val_q;
                pend_d  = 1'b0;
            end else begin
                hold_cnt_d = hold_cnt_q - 1'b1;
            end
        end

        if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = '0;
            busy_d      = 1'b1;
            addressed_d = 1'b0;
            pend_d      = 1'b0;
            sda_t_d     = 1'b1;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
            pend_d      = 1'b0;
            sda_t_d     = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == addr) begin
                                state_d     = ST_ADDR_ACK;
                                addressed_d = 1'b1;
                                rnw_d       = rx_byte[RW_BIT];
                                ack_rise_d  = 1'b0;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise) begin
                        ack_rise_d     = 1'b1;
                        data_request_d = rnw_q;
                    end
                    if (scl_fall) begin
                        sched = 1'b1;
                        if (!ack_rise_q) begin
                            sched_val = ACK;
                        end else if (rnw_q) begin
                            state_d   = ST_READ;
                            bit_cnt_d = '0;
                            tx_d      = data_i;
                            sched_val = data_i[7];
                        end else begin
                            state_d   = ST_WRITE;
                            bit_cnt_d = '0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_o_d     = rx_byte;
                            data_valid_d = 1'b1;
                            state_d      = ST_WRITE_ACK;
                            ack_rise_d   = 1'b0;
                        end
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_rise) begin
                        ack_rise_d = 1'b1;
                    end
                    if (scl_fall) begin
                        sched = 1'b1;
                        if (!ack_rise_q) begin
                            sched_val = ACK;
                        end else begin
                            state_d   = ST_WRITE;
                            bit_cnt_d = '0;
                        end
                    end
                end
                ST_READ: begin
                    if (scl_fall) begin
                        sched     = 1'b1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_READ_ACK;
                        end else begin
                            tx_d      = {tx_q[6:0], 1'b0};
                            sched_val = tx_q[6];
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == NACK) begin
                            state_d = ST_IGNORE;
                        end else begin
                            data_request_d = 1'b1;
                        end
                    end
                    if (scl_fall) begin
                        state_d   = ST_READ;
                        bit_cnt_d = '0;
                        tx_d      = data_i;
                        sched     = 1'b1;
                        sched_val = data_i[7];
                    end
                end
                default: ;
            endcase
        end

        if (sched) begin
            pend_d     = 1'b1;
            pend_val_d = sched_val;
            hold_cnt_d = HOLD_W'(SDA_HOLD - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            tx_q           <= '0;
            data_o_q       <= '0;
            busy_q         <= 1'b0;
            addressed_q    <= 1'b0;
            rnw_q          <= 1'b0;
            data_valid_q   <= 1'b0;
            data_request_q <= 1'b0;
            ack_rise_q     <= 1'b0;
            sda_t_q        <= 1'b1;
            pend_q         <= 1'b0;
            pend_val_q     <= 1'b1;
            hold_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            tx_q           <= tx_d;
            data_o_q       <= data_o_d;
            busy_q         <= busy_d;
            addressed_q    <= addressed_d;
            rnw_q          <= rnw_d;
            data_valid_q   <= data_valid_d;
            data_request_q <= data_request_d;
            ack_rise_q     <= ack_rise_d;
            sda_t_q        <= sda_t_d;
            pend_q         <= pend_d;
            pend_val_q     <= pend_val_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign busy         = busy_q;
    assign addressed    = addressed_q;
    assign read_nwrite  = rnw_q;
    assign data_o       = data_o_q;
    assign data_valid   = data_valid_q;
    assign data_request = data_request_q;
    assign SDA_o        = 1'b0;
    assign SDA_t        = sda_t_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bus-level master model drives transactions from a
// directed table and random vectors; expectations come from transaction rules.
module tb_i2c_slave;

    localparam int Q    = 10;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] addr;
    logic [7:0] data_i;
    logic       scl_m, sda_m;
    logic       busy, addressed, read_nwrite, data_valid, data_request;
    logic [7:0] data_o;
    logic       SDA_o, SDA_t;
    logic       sda_bus;

    assign sda_bus = sda_m & (SDA_t ? 1'b1 : SDA_o);

    i2c_slave #(.SDA_HOLD(HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .busy         (busy),
        .addressed    (addressed),
        .read_nwrite  (read_nwrite),
        .data_o       (data_o),
        .data_valid   (data_valid),
        .data_request (data_request),
        .data_i       (data_i),
        .SCL_i        (scl_m),
        .SDA_i        (sda_bus),
        .SDA_o        (SDA_o),
        .SDA_t        (SDA_t)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]      own;
        logic [6:0]      tgt;
        logic            rw;
        int              n;
        logic [3:0][7:0] b;
        logic            expAck;
        int              expValid;
        int              expReq;
    } vec_t;

    int         checks = 0;
    int         passes = 0;
    int         reqCount = 0;
    int         holdViol = 0;
    logic [7:0] dvQ[$];
    logic [7:0] userQ[$];
    logic       prevSdaT = 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Bytes received, read requests served from userQ, and SDA edges during SCL high.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (data_valid) dvQ.push_back(data_o);
            if (data_request) begin
                reqCount++;
                data_i = (userQ.size() > 0) ? userQ.pop_front() : 8'h00;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst && SDA_t !== prevSdaT && scl_m) holdViol++;
        prevSdaT = SDA_t;
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitQ();
        repeat (Q) @(negedge clk);
    endtask

    task automatic busStart();
        sda_m = 1'b1; waitQ();
        scl_m = 1'b1; waitQ();
        sda_m = 1'b0; waitQ();
        scl_m = 1'b0; waitQ();
    endtask

    task automatic busStop();
        sda_m = 1'b0; waitQ();
        scl_m = 1'b1; waitQ();
        sda_m = 1'b1; waitQ();
    endtask

    task automatic busBit(input logic b, output logic s);
        sda_m = b;    waitQ();
        scl_m = 1'b1; waitQ();
        s = sda_bus;  waitQ();
        scl_m = 1'b0; waitQ();
    endtask

    task automatic busWriteByte(input logic [7:0] v, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) busBit(v[i], s);
        busBit(1'b1, ack);
    endtask

    task automatic busReadByte(output logic [7:0] v, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            busBit(1'b1, s);
            v[i] = s;
        end
        busBit(nack, s);
    endtask

    // Transaction-level expectations: the target answers only its own address.
    function automatic vec_t modelExpect(input vec_t v);
        vec_t r = v;
        r.expAck   = (v.tgt == v.own);
        r.expValid = (r.expAck && !v.rw) ? v.n : 0;
        r.expReq   = (r.expAck && v.rw) ? v.n : 0;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        logic       ack;
        logic [7:0] got;
        int         dataAcks = 0;
        dvQ.delete();
        userQ.delete();
        reqCount = 0;
        if (v.rw) for (int i = 0; i < v.n; i++) userQ.push_back(v.b[i]);
        addr = v.own;
        busStart();
        busWriteByte({v.tgt, v.rw}, ack);
        checkOutput("addr_ack", 32'(!ack), 32'(v.expAck));
        checkOutput("busy_mid", 32'(busy), 32'd1);
        checkOutput("addressed_mid", 32'(addressed), 32'(v.expAck));
        if (v.expAck) checkOutput("read_nwrite", 32'(read_nwrite), 32'(v.rw));
        for (int i = 0; i < v.n; i++) begin
            if (v.rw) begin
                busReadByte(got, i == v.n - 1);
                checkOutput("read_byte", 32'(got), 32'(v.expAck ? v.b[i] : 8'hFF));
            end else begin
                busWriteByte(v.b[i], ack);
                if (!ack) dataAcks++;
            end
        end
        if (!v.rw) checkOutput("data_acks", dataAcks, v.expAck ? v.n : 0);
        busStop();
        waitQ();
        checkOutput("busy_idle", 32'(busy), 32'd0);
        checkOutput("addressed_idle", 32'(addressed), 32'd0);
        checkOutput("sda_released", 32'(SDA_t), 32'd1);
        checkOutput("valid_count", dvQ.size(), v.expValid);
        for (int i = 0; i < dvQ.size() && i < v.n; i++)
            checkOutput("data_o", 32'(dvQ[i]), 32'(v.b[i]));
        checkOutput("request_count", reqCount, v.expReq);
    endtask

    initial begin
        vec_t       vecs[6];
        vec_t       v;
        logic       ack;
        logic       s;
        logic [7:0] got;
        int         cnt;
        logic       seen;

        vecs[0] = '{own: 7'h42, tgt: 7'h42, rw: 1'b0, n: 2, b: '0, expAck: 1'b1, expValid: 2, expReq: 0};
        vecs[0].b[0] = 8'hA5; vecs[0].b[1] = 8'h3C;
        vecs[1] = '{own: 7'h42, tgt: 7'h42, rw: 1'b1, n: 2, b: '0, expAck: 1'b1, expValid: 0, expReq: 2};
        vecs[1].b[0] = 8'h96; vecs[1].b[1] = 8'h0F;
        vecs[2] = '{own: 7'h42, tgt: 7'h17, rw: 1'b0, n: 1, b: '0, expAck: 1'b0, expValid: 0, expReq: 0};
        vecs[2].b[0] = 8'h55;
        vecs[3] = '{own: 7'h17, tgt: 7'h17, rw: 1'b0, n: 3, b: '0, expAck: 1'b1, expValid: 3, expReq: 0};
        vecs[3].b[0] = 8'h01; vecs[3].b[1] = 8'h80; vecs[3].b[2] = 8'hFF;
        vecs[4] = '{own: 7'h42, tgt: 7'h17, rw: 1'b1, n: 1, b: '0, expAck: 1'b0, expValid: 0, expReq: 0};
        vecs[4].b[0] = 8'h33;
        vecs[5] = '{own: 7'h7F, tgt: 7'h7F, rw: 1'b1, n: 3, b: '0, expAck: 1'b1, expValid: 0, expReq: 3};
        vecs[5].b[0] = 8'h00; vecs[5].b[1] = 8'hFF; vecs[5].b[2] = 8'h5A;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; addr = 7'h42; data_i = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_SDA_t", 32'(SDA_t), 32'd1);
        checkOutput("rst_SDA_o", 32'(SDA_o), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_addressed", 32'(addressed), 32'd0);
        checkOutput("rst_read_nwrite", 32'(read_nwrite), 32'd0);
        checkOutput("rst_data_o", 32'(data_o), 32'd0);
        checkOutput("rst_data_valid", 32'(data_valid), 32'd0);
        checkOutput("rst_data_request", 32'(data_request), 32'd0);
        rst = 1'b0;
        waitQ();

        for (int k = 0; k < 6; k++) applyStimulus(vecs[k]);

        for (int k = 0; k < 8; k++) begin
            v.own = 7'($urandom_range(127, 0));
            v.tgt = ($urandom_range(1, 0) == 1) ? v.own : 7'($urandom_range(127, 0));
            v.rw  = 1'($urandom_range(1, 0));
            v.n   = $urandom_range(3, 1);
            for (int i = 0; i < 4; i++) v.b[i] = 8'($urandom_range(255, 0));
            applyStimulus(modelExpect(v));
        end

        // Repeated START: write one byte, then turn around into a read.
        dvQ.delete(); userQ.delete(); reqCount = 0;
        addr = 7'h42;
        busStart();
        busWriteByte(8'h84, ack);
        checkOutput("rs_w_addr_ack", 32'(ack), 32'd0);
        checkOutput("rs_rnw_write", 32'(read_nwrite), 32'd0);
        busWriteByte(8'h11, ack);
        checkOutput("rs_w_data_ack", 32'(ack), 32'd0);
        busStart();
        checkOutput("rs_addressed_cleared", 32'(addressed), 32'd0);
        checkOutput("rs_no_request_yet", reqCount, 0);
        userQ.push_back(8'hC3);
        busWriteByte(8'h85, ack);
        checkOutput("rs_r_addr_ack", 32'(ack), 32'd0);
        checkOutput("rs_rnw_read", 32'(read_nwrite), 32'd1);
        checkOutput("rs_request", reqCount, 1);
        busReadByte(got, 1'b1);
        checkOutput("rs_read_byte", 32'(got), 32'hC3);
        busStop();
        waitQ();
        checkOutput("rs_valid_count", dvQ.size(), 1);
        if (dvQ.size() > 0) checkOutput("rs_data_o", 32'(dvQ[0]), 32'h11);

        // STOP in the middle of a data byte.
        dvQ.delete();
        busStart();
        busWriteByte(8'h84, ack);
        checkOutput("ms_addr_ack", 32'(ack), 32'd0);
        busBit(1'b1, s); busBit(1'b0, s); busBit(1'b1, s); busBit(1'b0, s);
        busStop();
        waitQ();
        checkOutput("ms_no_valid", dvQ.size(), 0);
        checkOutput("ms_sda_released", 32'(SDA_t), 32'd1);
        checkOutput("ms_busy", 32'(busy), 32'd0);

        // ACK hold delay, then reset while the ACK is being driven.
        busStart();
        for (int i = 7; i >= 1; i--) busBit(8'h84 >> i, s);
        sda_m = 1'b0; waitQ();
        scl_m = 1'b1; waitQ(); waitQ();
        scl_m = 1'b0;
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            cnt++;
            if (SDA_t == 1'b0) seen = 1'b1;
        end
        checkOutput("ack_hold_delay", cnt, 3 + HOLD);
        @(negedge clk);
        checkOutput("ack_driven", 32'(SDA_t), 32'd0);
        checkOutput("ack_addressed", 32'(addressed), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rr_SDA_t", 32'(SDA_t), 32'd1);
        checkOutput("rr_busy", 32'(busy), 32'd0);
        checkOutput("rr_addressed", 32'(addressed), 32'd0);
        checkOutput("rr_data_o", 32'(data_o), 32'd0);
        checkOutput("rr_read_nwrite", 32'(read_nwrite), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        waitQ();
        busStop();
        waitQ();
        applyStimulus(vecs[0]);

        checkOutput("sda_hold_violations", holdViol, 0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) endpoint: the responder-side counterpart of `i2c_master` on the same two-wire bus. It watches SCL/SDA, detects START/STOP, matches a 7-bit address, ACKs, receives write bytes onto a byte interface and transmits read bytes requested from the user logic. It drives only SDA (open-drain, tri-state split like the master) and never stretches SCL.

## Interface
- `SDA_HOLD`, default 4: `clk` cycles after a detected SCL falling edge before the SDA output changes (≥1).
- `clk`  in  1  system clock; must be ≥20× SCL frequency.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  7  own I2C address; sampled at each address byte.
- `busy`  out  1  high from START to STOP while the bus is in use by any master.
- `addressed`  out  1  high while this target is selected (address ACKed until STOP/repeated START).
- `read_nwrite`  out  1  R/W bit of the current selected transfer (1: master reads).
- `data_o`  out  8  last byte received from master.
- `data_valid`  out  1  one-`clk` pulse: new byte on `data_o`.
- `data_request`  out  1  one-`clk` pulse: user must present next read byte on `data_i`.
- `data_i`  in  8  byte to transmit to master.
- `SCL_i`  in  1  SCL line.
- `SDA_i`  in  1  SDA line.
- `SDA_o`  out  1  SDA drive value (always 0 when driven).
- `SDA_t`  out  1  1: SDA released (tri-state), 0: driven.

## Operation
- SCL_i, SDA_i pass through 2-flop synchronizers; edges detected from synced value vs. one-cycle delayed copy.
- START: SCL high & SDA falling; STOP: SCL high & SDA rising. Both override every state, including mid-byte.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- IDLE --START--> ADDR; any state --START--> ADDR (repeated START); any state --STOP--> IDLE.
- ADDR: shift SDA in on each SCL rising edge, MSB first; after 8th bit: match `{addr}` → ADDR_ACK, latch `read_nwrite`; else → IGNORE.
- ADDR_ACK: drive SDA low for the ACK clock; on its SCL falling edge → READ (R/W=1) or WRITE (R/W=0). `addressed` set on entry.
- WRITE: 8 bits shifted in; at 8th SCL rising edge load `data_o`, pulse `data_valid` → WRITE_ACK (always ACK low); ACK falling edge → WRITE.
- READ: shift register MSB driven on SDA (0 → drive low, 1 → release); shift on each SCL falling edge; after 8th bit falling edge → READ_ACK (SDA released).
- READ_ACK: sample master ACK at SCL rising edge; ACK(0) → pulse `data_request`, back to READ on falling edge; NACK(1) → IGNORE.
- Read byte load: `data_request` pulses at SCL rising edge of ADDR_ACK (read) and of an ACKed READ_ACK; `data_i` latched at the following SCL falling edge.
- IGNORE: SDA released, waits for START/STOP.
- 3-bit bit counter, wraps 7→0 at byte end; reset on START and entry to each data/addr state.

## Timing
- Reset values: `SDA_t`=1, `SDA_o`=0, `busy`=0, `addressed`=0, `read_nwrite`=0, `data_o`=8'h00, `data_valid`=0, `data_request`=0; state IDLE.
- Line-to-detection latency: 3 `clk` (2 sync + edge compare).
- SDA changes exactly `SDA_HOLD` `clk` after detected SCL falling edge; never while synced SCL high.
- `data_valid` asserted 1 `clk` after detected 8th SCL rising edge; `data_o` stable until next `data_valid`.
- User has ≥ half SCL period minus (`SDA_HOLD`+3) `clk` from `data_request` to valid `data_i`.
- `rst` mid-transfer: SDA released next cycle, all outputs to reset values, wait for next START.
- STOP/START during pending hold count: cancel update, release SDA.

## Structure
- Shared package `i2c_pkg`: state encoding constants, ACK/NACK values, R/W bit position.
- One sub-module natural: `i2c_line_sync` (2-flop synchronizer + rise/fall edge outputs), instanced for SCL and SDA.

## Test plan
- Write 0x42, bytes 0xA5,0x3C, STOP → ACK on all 3 bytes; `data_valid` twice with `data_o`=0xA5 then 0x3C; `busy`/`addressed` drop after STOP.
- Read 0x42, `data_i`=0x96 then 0x0F, master ACK then NACK → SDA bits 10010110, 00001111; two `data_request` pulses; SDA released after NACK.
- Address 0x17 while `addr`=0x42 → no ACK (SDA released at 9th clock), no pulses, `busy`=1 until STOP.
- Write 0x42 + 0x11, repeated START, read 0x42 → `read_nwrite` 0→1, `data_request` after second address ACK.
- STOP injected mid-byte (bit 4 of write data) → IDLE, no `data_valid`, SDA released.
- `rst` asserted while driving ACK low → `SDA_t`=1 next cycle, all outputs reset; next transaction ACKed normally.
